// File: rtl/thermocouple_pkg.sv
// Frame layout, FSM states and the frame-pack helper shared by the responder and the reader side.
package thermocouple_pkg;

    localparam int FRAME_W       = 32;
    localparam int TC_MSB        = 31;
    localparam int TC_LSB        = 18;
    localparam int FAULT_ANY_BIT = 16;
    localparam int JT_MSB        = 15;
    localparam int JT_LSB        = 4;
    localparam int FAULT_MSB     = 2;

    localparam int TC_W    = TC_MSB - TC_LSB + 1;
    localparam int JT_W    = JT_MSB - JT_LSB + 1;
    localparam int FAULT_W = FAULT_MSB + 1;
    localparam int RISE_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [TC_W-1:0]    tc;
        logic [JT_W-1:0]    jt;
        logic [FAULT_W-1:0] fault;
    } sample_t;

    // Reserved bits 17 and 3 stay zero.
    function automatic logic [FRAME_W-1:0] pack_frame(input sample_t s);
        logic [FRAME_W-1:0] f;
        f                  = '0;
        f[TC_MSB:TC_LSB]   = s.tc;
        f[FAULT_ANY_BIT]   = |s.fault;
        f[JT_MSB:JT_LSB]   = s.jt;
        f[FAULT_MSB:0]     = s.fault;
        return f;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises one asynchronous SPI pin into clk and flags its rise/fall edges.
// Edge pulses appear SYNC_STAGES clk after the pin changes; no flow control.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// SPI slave model of a thermocouple converter: periodic input snapshot, 32-bit MSB-first frame on miso.
// miso updates at most SYNC_STAGES+1 clk after an sclk/cs_n pin edge; the master paces everything.
module thermocouple_spi_responder
    import thermocouple_pkg::*;
#(
    parameter int CONV_CYCLES = 600,
    parameter int CBITS       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TC_W-1:0]    tc_temp_in,
    input  logic [JT_W-1:0]    junction_temp_in,
    input  logic [FAULT_W-1:0] fault_in,
    input  logic               sclk,
    input  logic               cs_n,
    output logic               miso,
    output logic               frame_done,
    output logic               frame_abort
);

    localparam logic [RISE_W-1:0] FULL_RISES = RISE_W'(FRAME_W);
    localparam logic [CBITS-1:0]  CONV_LAST  = CBITS'(CONV_CYCLES - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    state_t             state_q, state_d;
    sample_t            sample_q, sample_d;
    logic [CBITS-1:0]   conv_q, conv_d;
    logic               pending_q, pending_d;
    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [RISE_W-1:0]  rise_q, rise_d;
    logic               miso_q, miso_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    sample_t            live_sample;
    logic [FRAME_W-1:0] load_frame;
    logic               wrap;
    logic               capture;

    assign live_sample = {tc_temp_in, junction_temp_in, fault_in};
    assign load_frame  = pack_frame(sample_q);
    assign wrap        = (conv_q == CONV_LAST);
    // A frame starting this cycle keeps the old sample; the wrap is deferred via pending.
    assign capture     = (state_q == IDLE) && !cs_fall && (wrap || pending_q);

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        conv_d    = wrap ? '0 : conv_q + 1'b1;
        pending_d = pending_q;
        sr_d      = sr_q;
        rise_d    = rise_q;
        miso_d    = miso_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        if (capture) begin
            sample_d  = live_sample;
            pending_d = 1'b0;
        end else if (wrap) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    sr_d    = load_frame;
                    miso_d  = load_frame[FRAME_W-1];
                    rise_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    done_d  = (rise_q == FULL_RISES);
                    abort_d = (rise_q != FULL_RISES);
                end else if (sclk_rise) begin
                    rise_d = rise_q + 1'b1;
                    if (rise_q == FULL_RISES - 1'b1) begin
                        state_d = DRAIN;
                        miso_d  = 1'b0;
                    end
                end else if (sclk_fall) begin
                    sr_d   = {sr_q[FRAME_W-2:0], 1'b0};
                    miso_d = sr_q[FRAME_W-2];
                end
            end
            DRAIN: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                    done_d  = (rise_q == FULL_RISES);
                    abort_d = (rise_q != FULL_RISES);
                end else if (sclk_rise && rise_q != FULL_RISES) begin
                    rise_d = rise_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            conv_q    <= '0;
            pending_q <= 1'b0;
            sr_q      <= '0;
            rise_q    <= '0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            conv_q    <= conv_d;
            pending_q <= pending_d;
            sr_q      <= sr_d;
            rise_q    <= rise_d;
            miso_q    <= miso_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign miso        = miso_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Directed bench: an SPI master at clk/8 reads frames and checks data and end-of-frame pulses.
module tb_thermocouple_spi_responder;

    logic        clk;
    logic        rst;
    logic [13:0] tc_temp_in;
    logic [11:0] junction_temp_in;
    logic [2:0]  fault_in;
    logic        sclk;
    logic        cs_n;
    logic        miso;
    logic        frame_done;
    logic        frame_abort;

    int tests;
    int fails;
    int done_cnt;
    int abort_cnt;

    thermocouple_spi_responder dut (
        .clk              (clk),
        .rst              (rst),
        .tc_temp_in       (tc_temp_in),
        .junction_temp_in (junction_temp_in),
        .fault_in         (fault_in),
        .sclk             (sclk),
        .cs_n             (cs_n),
        .miso             (miso),
        .frame_done       (frame_done),
        .frame_abort      (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Master samples miso as it raises sclk; half period is 4 clk.
    task automatic spi_xfer(input int nrise, input bit release_cs, output logic [63:0] rx);
        rx   = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            sclk = 1'b1;
            rx   = {rx[62:0], miso};
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (release_cs) begin
            cs_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] rx;
        int d0;
        int a0;

        tests     = 0;
        fails     = 0;
        done_cnt  = 0;
        abort_cnt = 0;
        rst              = 1'b1;
        cs_n             = 1'b1;
        sclk             = 1'b0;
        tc_temp_in       = '0;
        junction_temp_in = '0;
        fault_in         = '0;

        repeat (3) @(negedge clk);
        check("reset_miso",  {63'd0, miso},        64'd0);
        check("reset_done",  {63'd0, frame_done},  64'd0);
        check("reset_abort", {63'd0, frame_abort}, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Before the first conversion the sample is still zero.
        spi_xfer(32, 1'b1, rx);
        check("frame_after_reset", rx, 64'h0);

        tc_temp_in       = 14'h0190;
        junction_temp_in = 12'h190;
        fault_in         = 3'b000;
        repeat (610) @(negedge clk);
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_xfer(32, 1'b1, rx);
        check("basic_frame", rx, 64'h0640_1900);
        check("basic_done",  64'(done_cnt - d0),  64'd1);
        check("basic_abort", 64'(abort_cnt - a0), 64'd0);

        fault_in = 3'b001;
        repeat (610) @(negedge clk);
        spi_xfer(32, 1'b1, rx);
        check("fault_frame", rx, 64'h0641_1901);

        d0 = done_cnt;
        a0 = abort_cnt;
        spi_xfer(10, 1'b1, rx);
        check("short_abort", 64'(abort_cnt - a0), 64'd1);
        check("short_done",  64'(done_cnt - d0),  64'd0);
        spi_xfer(32, 1'b1, rx);
        check("after_abort_frame", rx, 64'h0641_1901);

        // Conversion wrap while selected must not disturb the frame in flight.
        tc_temp_in       = 14'h0100;
        junction_temp_in = 12'h050;
        fault_in         = 3'b000;
        repeat (610) @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        tc_temp_in       = 14'h00A0;
        junction_temp_in = 12'h0AA;
        fault_in         = 3'b100;
        repeat (620) @(negedge clk);
        spi_xfer(32, 1'b1, rx);
        check("stable_old_frame", rx, 64'h0400_0500);
        spi_xfer(32, 1'b1, rx);
        check("pending_new_frame", rx, 64'h0281_0AA4);

        tc_temp_in       = 14'h0190;
        junction_temp_in = 12'h190;
        fault_in         = 3'b001;
        repeat (610) @(negedge clk);
        d0 = done_cnt;
        spi_xfer(40, 1'b1, rx);
        check("long_frame_head", {32'd0, rx[39:8]}, 64'h0641_1901);
        check("long_frame_tail", {56'd0, rx[7:0]},  64'h0);
        check("long_done",       64'(done_cnt - d0), 64'd1);

        // Reset mid-frame while miso carries a 1.
        tc_temp_in       = 14'h3FFC;
        junction_temp_in = 12'hFF0;
        fault_in         = 3'b000;
        repeat (610) @(negedge clk);
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_miso", {63'd0, miso}, 64'd1);
        #3 rst = 1'b1;
        #1 check("async_reset_miso", {63'd0, miso}, 64'd0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("reset_no_pulse", 64'((done_cnt - d0) + (abort_cnt - a0)), 64'd0);
        spi_xfer(32, 1'b1, rx);
        check("post_reset_zero_frame", rx, 64'h0);
        repeat (610) @(negedge clk);
        spi_xfer(32, 1'b1, rx);
        check("post_reset_new_frame", rx, 64'hFFF0_FF00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
